// File: rtl/alu_seq_if.sv
// Handshaked operand/result bundle between the register-read stage and alu_seq.
// The master issues operations and consumes results; the slave is the ALU.
interface alu_seq_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] R;
  logic         cout;
  logic         overflow;
  logic         isZero;

  modport master (
    output in_valid, op, A, B, out_ready,
    input  in_ready, out_valid, R, cout, overflow, isZero
  );

  modport slave (
    input  in_valid, op, A, B, out_ready,
    output in_ready, out_valid, R, cout, overflow, isZero
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops, iterative SLL and unsigned
// shift-add MUL. Results and flags are registered and held until consumed.
module alu_seq #(
  parameter  int W  = 32,
  localparam int SW = $clog2(W),
  localparam int CW = $clog2(W) + 1
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_SLL = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  state_e         state;
  op_e            op_q;
  logic [W-1:0]   a_q;
  logic [2*W-1:0] work;      // MUL: {partial high, multiplier/low}; SLL: low half is the shifter
  logic [CW-1:0]  cnt;
  logic           sh_ovf;

  logic [W-1:0]   r_q;
  logic           cout_q;
  logic           ovf_q;
  logic           zero_q;
  logic           out_valid_q;

  // Single-cycle datapath on the live inputs
  op_e            op_in;
  logic           sub;
  logic [W-1:0]   b_x;
  logic [W:0]     sum;
  logic           c_msb;
  logic [SW-1:0]  shamt;
  logic [W-1:0]   alu_r;
  logic           alu_c;
  logic           alu_v;

  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path through the case statements can infer a latch.
  always_comb begin
    op_in = op_e'(bus.op);
    sub   = (op_in == OP_SUB);
    b_x   = bus.B ^ {W{sub}};
    sum   = {1'b0, bus.A} + {1'b0, b_x} + {{W{1'b0}}, sub};
    c_msb = bus.A[W-1] ^ b_x[W-1] ^ sum[W-1];
    shamt = bus.B[SW-1:0];
    alu_r = bus.A;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op_in)
      OP_ADD, OP_SUB: begin
        alu_r = sum[W-1:0];
        alu_c = sum[W];
        alu_v = c_msb ^ sum[W];
      end
      OP_AND:  alu_r = bus.A & bus.B;
      OP_OR:   alu_r = bus.A | bus.B;
      OP_XOR:  alu_r = bus.A ^ bus.B;
      OP_SLT:  alu_r = {{(W-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      default: alu_r = bus.A;  // SLL by zero passes A through
    endcase
  end

  // One iteration of the multi-cycle ops
  logic [W:0]     mul_add;
  logic [2*W-1:0] mul_next;
  logic [W-1:0]   sll_next;
  logic           sll_ovf_next;
  logic           last;

  always_comb begin
    mul_add      = {1'b0, work[2*W-1:W]} + (work[0] ? {1'b0, a_q} : {(W+1){1'b0}});
    mul_next     = {mul_add, work[W-1:1]};
    sll_next     = {work[W-2:0], 1'b0};
    sll_ovf_next = sh_ovf | work[W-1];
    last         = (cnt == CW'(1));
  end

  // Result write: one place decides when R/flags change and with what
  logic         wr_en;
  logic [W-1:0] wr_r;
  logic         wr_c;
  logic         wr_v;

  always_comb begin
    wr_en = 1'b0;
    wr_r  = alu_r;
    wr_c  = alu_c;
    wr_v  = alu_v;
    case (state)
      IDLE: begin
        if (bus.in_valid && op_in != OP_MUL && !(op_in == OP_SLL && shamt != '0))
          wr_en = 1'b1;
      end
      EXEC: begin
        if (last) begin
          wr_en = 1'b1;
          wr_c  = 1'b0;
          if (op_q == OP_MUL) begin
            wr_r = mul_next[W-1:0];
            wr_v = |mul_next[2*W-1:W];
          end else begin
            wr_r = sll_next;
            wr_v = sll_ovf_next;
          end
        end
      end
      default: wr_en = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      work        <= '0;
      cnt         <= '0;
      sh_ovf      <= 1'b0;
      r_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (wr_en) begin
        r_q         <= wr_r;
        cout_q      <= wr_c;
        ovf_q       <= wr_v;
        zero_q      <= (wr_r == '0);
        out_valid_q <= 1'b1;
        state       <= DONE;
      end
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q   <= op_in;
            a_q    <= bus.A;
            sh_ovf <= 1'b0;
            if (op_in == OP_MUL) begin
              work  <= {{W{1'b0}}, bus.B};
              cnt   <= CW'(W);
              state <= EXEC;
            end else if (op_in == OP_SLL && shamt != '0) begin
              work  <= {{W{1'b0}}, bus.A};
              cnt   <= {1'b0, shamt};
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          cnt <= cnt - CW'(1);
          if (op_q == OP_MUL) begin
            work <= mul_next;
          end else begin
            work   <= {work[2*W-1:W], sll_next};
            sh_ovf <= sll_ovf_next;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.R         = r_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.isZero    = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at W=8: results, flags, latency,
// back-pressure hold and mid-operation reset.
module tb_alu_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.W(W)) bus ();
  alu_seq #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op and wait (bounded) for out_valid; lat=1 means valid right after accept edge
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    @(negedge clk);
    bus.op       = op;
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take_result(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_ovalid_after_take"}, bus.out_valid, 1'b0);
    check({tag, "_iready_after_take"}, bus.in_ready, 1'b1);
  endtask

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       c;
    logic       v;
    logic       z;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    //            name        op      A      B      R      c     v     z     lat
    vecs.push_back('{"add_ovf",  3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{"add_wrap", 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1});
    vecs.push_back('{"sub_eq",   3'b001, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1, 1});
    vecs.push_back('{"sub_brw",  3'b001, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{"sub_ovf",  3'b001, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 1});
    vecs.push_back('{"and",      3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{"or",       3'b011, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{"xor",      3'b100, 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{"slt_neg",  3'b101, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{"slt_ge",   3'b101, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{"mul_ff",   3'b111, 8'h0F, 8'h11, 8'hFF, 1'b0, 1'b0, 1'b0, 9});
    vecs.push_back('{"mul_ovf",  3'b111, 8'h10, 8'h10, 8'h00, 1'b0, 1'b1, 1'b1, 9});
    vecs.push_back('{"mul_max",  3'b111, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 9});
    vecs.push_back('{"sll_3",    3'b110, 8'h81, 8'h03, 8'h08, 1'b0, 1'b1, 1'b0, 4});
    vecs.push_back('{"sll_0",    3'b110, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{"sll_7",    3'b110, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 1'b0, 8});
    vecs.push_back('{"sll_hib",  3'b110, 8'h01, 8'h0B, 8'h08, 1'b0, 1'b0, 1'b0, 4});

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = 3'b000;
    bus.A         = '0;
    bus.B         = '0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ovalid", bus.out_valid, 1'b0);
    check("rst_iready", bus.in_ready, 1'b1);
    check("rst_R",      bus.R, 8'h00);
    check("rst_flags",  {bus.cout, bus.overflow, bus.isZero}, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check({vecs[i].name, "_lat"},  lat, vecs[i].lat);
      check({vecs[i].name, "_R"},    bus.R, vecs[i].r);
      check({vecs[i].name, "_cout"}, bus.cout, vecs[i].c);
      check({vecs[i].name, "_ovf"},  bus.overflow, vecs[i].v);
      check({vecs[i].name, "_zero"}, bus.isZero, vecs[i].z);
      check({vecs[i].name, "_iready_busy"}, bus.in_ready, 1'b0);
      take_result(vecs[i].name);
    end

    // Back-pressure: result held while in_valid pulses are ignored
    run_op(3'b100, 8'hA5, 8'h0F, lat);
    check("hold_R0", bus.R, 8'hAA);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op       = 3'b000;
      bus.A        = 8'h11 + 8'(k);
      bus.B        = 8'h22;
      @(posedge clk);
      #1;
      check("hold_R",      bus.R, 8'hAA);
      check("hold_flags",  {bus.cout, bus.overflow, bus.isZero}, 3'b000);
      check("hold_ovalid", bus.out_valid, 1'b1);
      check("hold_iready", bus.in_ready, 1'b0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    take_result("hold");
    check("hold_R_after", bus.R, 8'hAA);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("hold_no_accept", bus.out_valid, 1'b0);
    end

    // Reset three cycles into a MUL
    @(negedge clk);
    bus.op       = 3'b111;
    bus.A        = 8'h0F;
    bus.B        = 8'h11;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("mulrst_busy", bus.in_ready, 1'b0);
    rst = 1'b1;
    #1;
    check("mulrst_ovalid", bus.out_valid, 1'b0);
    check("mulrst_iready", bus.in_ready, 1'b1);
    check("mulrst_R",      bus.R, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      check("mulrst_no_stale", bus.out_valid, 1'b0);
    end
    run_op(3'b000, 8'h01, 8'h01, lat);
    check("post_rst_lat",  lat, 1);
    check("post_rst_R",    bus.R, 8'h02);
    check("post_rst_flags", {bus.cout, bus.overflow, bus.isZero}, 3'b000);
    take_result("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
